// File: rtl/a2_sigmoid_collect_pkg.sv
// Shared constants for the z2 -> a2 activation collector.
// Sigmoid is a 3-segment piecewise-linear fit over |z2| in Q4.4 LSBs.
package a2_sigmoid_collect_pkg;

    localparam int Z_W = 8;   // signed Q4.4 pre-activation
    localparam int A_W = 8;   // unsigned Q0.8 activation

    // Segment breakpoints on m = |z2| (integer LSBs)
    localparam logic [9:0] SIG_BP0 = 10'd16;
    localparam logic [9:0] SIG_BP1 = 10'd38;
    localparam logic [9:0] SIG_BP2 = 10'd80;

    // Segment offsets and the saturated output
    localparam logic [9:0] SIG_OFF0 = 10'd128;
    localparam logic [9:0] SIG_OFF1 = 10'd160;
    localparam logic [9:0] SIG_OFF2 = 10'd216;
    localparam logic [9:0] SIG_SAT  = 10'd255;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

endpackage

// File: rtl/a2_sigmoid_collect_sigmoid_pla.sv
// Combinational piecewise-linear sigmoid: signed Q4.4 in, unsigned Q0.8 out.
// Computes on |z| and mirrors around 0.5 for negative inputs (256 - y).
module sigmoid_pla
    import a2_sigmoid_collect_pkg::*;
(
    input  logic [Z_W-1:0] z,
    output logic [A_W-1:0] a
);

    logic [9:0] zs;
    logic [9:0] m;
    logic [9:0] y;
    logic [9:0] r;

    // Magnitude, segment select, saturation and sign mirror
    always_comb begin
        zs = {{2{z[Z_W-1]}}, z};
        // -8.0 (0x80) still yields m=128 thanks to the 10-bit intermediate
        m  = z[Z_W-1] ? (10'd0 - zs) : zs;
        if (m < SIG_BP0)
            y = (m << 2) + SIG_OFF0;
        else if (m < SIG_BP1)
            y = (m << 1) + SIG_OFF1;
        else if (m < SIG_BP2)
            y = {1'b0, m[9:1]} + SIG_OFF2;
        else
            y = SIG_SAT;
        if (y > SIG_SAT)
            y = SIG_SAT;
        // y >= 128 here, so 256-y never exceeds 128
        r = z[Z_W-1] ? (10'd256 - y) : y;
        a = r[A_W-1:0];
    end

endmodule

// File: rtl/a2_sigmoid_collect.sv
// Collects N_NEURON sigmoid activations of the z2 stream into one vector and
// presents it with valid/ready. One pipe stage sits between accept and the
// slot write; z2 is held off while the last slot is in flight or a vector is held.
// Optional: define A2_SAMPLE_CNT_EN to add the vec_cnt handshake counter port.
module a2_sigmoid_collect
    import a2_sigmoid_collect_pkg::*;
#(
    parameter int N_NEURON = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [Z_W-1:0]            z2_in,
    input  logic                      z2_valid,
    output logic                      z2_ready,
    output logic [N_NEURON*A_W-1:0]   a2_vec,
    output logic                      a2_valid,
    input  logic                      a2_ready
`ifdef A2_SAMPLE_CNT_EN
    ,
    output logic [15:0]               vec_cnt
`endif
);

    localparam int IDX_W = $clog2(N_NEURON);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURON - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx;
    logic             pipe_valid;
    logic [Z_W-1:0]   pipe_z;
    logic [IDX_W-1:0] pipe_idx;
    logic [A_W-1:0]   sig_y;
    logic             abort;
    logic             accept;
    logic             slot_wr;

    // clear only matters while collecting; a held vector is always delivered
    assign abort    = clear && (state_q == COLLECT);
    assign z2_ready = (state_q == COLLECT) && !(pipe_valid && (pipe_idx == LAST));
    assign accept   = z2_valid && z2_ready && !abort;
    assign slot_wr  = pipe_valid && !abort;
    assign a2_valid = (state_q == FULL);

    sigmoid_pla u_sig (
        .z (pipe_z),
        .a (sig_y)
    );

    // Pipe register and slot index counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            pipe_valid <= 1'b0;
            pipe_z     <= '0;
            pipe_idx   <= '0;
        end else if (abort) begin
            idx        <= '0;
            pipe_valid <= 1'b0;
        end else begin
            pipe_valid <= accept;
            if (accept) begin
                pipe_z   <= z2_in;
                pipe_idx <= idx;
                idx      <= (idx == LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Slot bank: activation lands one edge after accept; never cleared by handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            a2_vec <= '0;
        else if (slot_wr)
            a2_vec[int'(pipe_idx)*A_W +: A_W] <= sig_y;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= COLLECT;
        else
            state_q <= state_d;
    end

    // FSM next state: full once the last slot is written, back on handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (slot_wr && (pipe_idx == LAST)) state_d = FULL;
            FULL:    if (a2_ready)                      state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

`ifdef A2_SAMPLE_CNT_EN
    // Delivered-vector counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            vec_cnt <= '0;
        else if (a2_valid && a2_ready)
            vec_cnt <= vec_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_a2_sigmoid_collect.sv
// Directed + randomized bench for a2_sigmoid_collect (N_NEURON=3).
// Reference: accepted samples queued, sigmoid evaluated from the segment table.
module tb_a2_sigmoid_collect;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  z2_in = 8'h00;
    logic        z2_valid = 1'b0;
    logic        z2_ready;
    logic [23:0] a2_vec;
    logic        a2_valid;
    logic        a2_ready = 1'b0;
`ifdef A2_SAMPLE_CNT_EN
    logic [15:0] vec_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int hs    = 0;
    logic [7:0] q[$];

    a2_sigmoid_collect #(.N_NEURON(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .z2_in    (z2_in),
        .z2_valid (z2_valid),
        .z2_ready (z2_ready),
        .a2_vec   (a2_vec),
        .a2_valid (a2_valid),
        .a2_ready (a2_ready)
`ifdef A2_SAMPLE_CNT_EN
        ,
        .vec_cnt  (vec_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference sigmoid straight from the segment table
    function automatic logic [7:0] sig(input logic [7:0] z);
        int v, m, y;
        v = int'($signed(z));
        m = (v < 0) ? -v : v;
        if (m < 16)      y = 4 * m + 128;
        else if (m < 38) y = 2 * m + 160;
        else if (m < 80) y = m / 2 + 216;
        else             y = 255;
        if (y > 255) y = 255;
        if (v < 0) y = 256 - y;
        return 8'(y);
    endfunction

    function automatic logic [23:0] model_vec();
        return {sig(q[2]), sig(q[1]), sig(q[0])};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one sample and wait (bounded) for it to be accepted
    task automatic push(input logic [7:0] z);
        int n;
        z2_in = z;
        z2_valid = 1'b1;
        n = 0;
        while (!z2_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("push_wait", {63'd0, z2_ready}, 64'd1);
        @(posedge clk); #1;
        q.push_back(z);
        z2_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!a2_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_wait"}, {63'd0, a2_valid}, 64'd1);
    endtask

    task automatic take_vec(input string tag);
        wait_valid(tag);
        chk(tag, {40'd0, a2_vec}, {40'd0, model_vec()});
        a2_ready = 1'b1;
        @(posedge clk); #1;
        a2_ready = 1'b0;
        hs++;
        q.delete();
        chk({tag, "_drop"}, {63'd0, a2_valid}, 64'd0);
    endtask

    initial begin
        logic [23:0] held;
        logic [7:0]  s4;

        // Reset state
        #12;
        chk("rst_valid", {63'd0, a2_valid}, 64'd0);
        chk("rst_vec",   {40'd0, a2_vec},   64'd0);
        chk("rst_ready", {63'd0, z2_ready}, 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: streaming with consumer always ready; one-cycle valid pulse
        a2_ready = 1'b1;
        push(8'h3F); push(8'h66); push(8'h59);
        chk("t1_early",  {63'd0, a2_valid}, 64'd0);
        chk("t1_block",  {63'd0, z2_ready}, 64'd0);
        @(posedge clk); #1;
        chk("t1_valid",  {63'd0, a2_valid}, 64'd1);
        chk("t1_vec",    {40'd0, a2_vec},   64'hFFFFF7);
        hs++;
        @(posedge clk); #1;
        chk("t1_pulse",  {63'd0, a2_valid}, 64'd0);
        chk("t1_rdy",    {63'd0, z2_ready}, 64'd1);
        a2_ready = 1'b0;
        q.delete();

        // 2: signed points and breakpoints
        push(8'hF0); push(8'h00); push(8'h80);
        wait_valid("t2_signed");
        chk("t2_signed", {40'd0, a2_vec}, 64'h018040);
        a2_ready = 1'b1; @(posedge clk); #1; a2_ready = 1'b0; hs++; q.delete();
        push(8'h0F); push(8'h10); push(8'h25); take_vec("t2_bp_lo");
        push(8'h26); push(8'h4F); push(8'h50); take_vec("t2_bp_hi");
        push(8'hF1); push(8'hDB); push(8'hDA); take_vec("t2_bp_nlo");
        push(8'hB1); push(8'hB0); push(8'h7F); take_vec("t2_bp_nhi");

        // random vectors
        for (int i = 0; i < 8; i++) begin
            push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
            take_vec("rand");
        end

        // 3/4: backpressure with a 4th sample waiting on z2_valid
        push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
        wait_valid("t3");
        chk("t3_vec", {40'd0, a2_vec}, {40'd0, model_vec()});
        held = a2_vec;
        s4 = 8'($urandom);
        z2_in = s4;
        z2_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t3_stable", {40'd0, a2_vec},   {40'd0, held});
            chk("t3_hold",   {63'd0, z2_ready}, 64'd0);
        end
        a2_ready = 1'b1;
        @(posedge clk); #1;
        a2_ready = 1'b0;
        hs++;
        q.delete();
        chk("t3_done",  {63'd0, a2_valid}, 64'd0);
        chk("t3_rdy",   {63'd0, z2_ready}, 64'd1);
        chk("t3_keep",  {40'd0, a2_vec},   {40'd0, held});
        push(s4); push(8'($urandom)); push(8'($urandom));
        take_vec("t3_next");

        // 5: clear mid-vector, then clear while full
        push(8'($urandom)); push(8'($urandom));
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        q.delete();
        chk("t5_noval", {63'd0, a2_valid}, 64'd0);
        push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
        take_vec("t5_after_clr");
        push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
        wait_valid("t5_full");
        clear = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_full_hold", {63'd0, a2_valid}, 64'd1);
        clear = 1'b0;
        take_vec("t5_full_vec");

        // 6: asynchronous reset mid-vector
        push(8'($urandom)); push(8'($urandom));
        #3;
        reset = 1'b0;
        #1;
        chk("t6_valid", {63'd0, a2_valid}, 64'd0);
        chk("t6_vec",   {40'd0, a2_vec},   64'd0);
        chk("t6_ready", {63'd0, z2_ready}, 64'd1);
        q.delete();
        hs = 0;
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
        take_vec("t6_after");
        push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
        take_vec("t6_after2");
        push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
        take_vec("t6_after3");
`ifdef A2_SAMPLE_CNT_EN
        chk("vec_cnt", {48'd0, vec_cnt}, 64'(hs));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
